// File: rtl/exec_pkg.sv
// Shared definitions for the execute/writeback sequencer: widths, opcodes,
// instruction field positions, FSM states and opcode class helpers.
package exec_pkg;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned ADDR_W  = 3;
  localparam int unsigned INSTR_W = 16;
  localparam int unsigned OP_W    = 4;

  localparam logic [OP_W-1:0] OP_NOP = 4'd0;
  localparam logic [OP_W-1:0] OP_ADD = 4'd1;
  localparam logic [OP_W-1:0] OP_SUB = 4'd2;
  localparam logic [OP_W-1:0] OP_AND = 4'd3;
  localparam logic [OP_W-1:0] OP_OR  = 4'd4;
  localparam logic [OP_W-1:0] OP_XOR = 4'd5;
  localparam logic [OP_W-1:0] OP_SHL = 4'd6;
  localparam logic [OP_W-1:0] OP_SHR = 4'd7;
  localparam logic [OP_W-1:0] OP_LDI = 4'd8;
  localparam logic [OP_W-1:0] OP_MOV = 4'd9;

  localparam int unsigned OP_MSB   = 15;
  localparam int unsigned OP_LSB   = 12;
  localparam int unsigned DST_MSB  = 11;
  localparam int unsigned DST_LSB  = 9;
  localparam int unsigned SRC1_MSB = 8;
  localparam int unsigned SRC1_LSB = 6;
  localparam int unsigned SRC2_MSB = 5;
  localparam int unsigned SRC2_LSB = 3;
  localparam int unsigned IMM_MSB  = 7;
  localparam int unsigned IMM_LSB  = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_EXEC,
    ST_WRITE
  } state_t;

  // Ops that read src1 from the register file (everything that goes through READ).
  function automatic logic is_reg_op(input logic [OP_W-1:0] op);
    return (op inside {[OP_ADD:OP_SHR], OP_MOV});
  endfunction

  function automatic logic uses_src2(input logic [OP_W-1:0] op);
    return (op inside {[OP_ADD:OP_XOR]});
  endfunction

  function automatic logic sets_flags(input logic [OP_W-1:0] op);
    return (op inside {[OP_ADD:OP_SHR]});
  endfunction

  function automatic logic is_illegal(input logic [OP_W-1:0] op);
    return (op > OP_MOV);
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: result plus carry/borrow and zero for one opcode.
// MOV passes operand a through; ops without an ALU function yield zero.
module alu_core
  import exec_pkg::*;
#(
  parameter int unsigned DATA_W = exec_pkg::DATA_W
) (
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              c,
  output logic              z
);

  logic [DATA_W:0] wide;

  always_comb begin
    wide   = '0;
    result = '0;
    c      = 1'b0;
    case (op)
      OP_ADD: begin
        wide   = {1'b0, a} + {1'b0, b};
        result = wide[DATA_W-1:0];
        c      = wide[DATA_W];
      end
      OP_SUB: begin
        // Top bit of the widened difference is the unsigned borrow.
        wide   = {1'b0, a} - {1'b0, b};
        result = wide[DATA_W-1:0];
        c      = wide[DATA_W];
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_SHL: begin
        result = {a[DATA_W-2:0], 1'b0};
        c      = a[DATA_W-1];
      end
      OP_SHR: begin
        result = {1'b0, a[DATA_W-1:1]};
        c      = a[0];
      end
      OP_MOV: result = a;
      default: begin
        result = '0;
        c      = 1'b0;
      end
    endcase
    z = (result == '0);
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute/writeback sequencer around an 8x8 register file: accepts one
// instruction per handshake, reads operands, runs the ALU and writes back.
module alu_exec_unit
  import exec_pkg::*;
#(
  parameter int unsigned DATA_W = exec_pkg::DATA_W,
  parameter int unsigned ADDR_W = exec_pkg::ADDR_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [INSTR_W-1:0]  instr,
  input  logic                instr_valid,
  output logic                instr_ready,
  output logic [ADDR_W-1:0]   rd_addr1,
  output logic [ADDR_W-1:0]   rd_addr2,
  output logic                rd_en1,
  output logic                rd_en2,
  input  logic [DATA_W-1:0]   rd_data1,
  input  logic [DATA_W-1:0]   rd_data2,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [DATA_W-1:0]   wr_data,
  output logic                wr_en,
  output logic                busy,
  output logic                done,
  output logic                flag_z,
  output logic                flag_c,
  output logic                illegal_op
);

  state_t              state;
  logic [OP_W-1:0]     op_q;
  logic [ADDR_W-1:0]   dst_q;
  logic [ADDR_W-1:0]   src1_q;
  logic [ADDR_W-1:0]   src2_q;
  logic [DATA_W-1:0]   result_q;

  logic [OP_W-1:0]     in_op;
  logic [ADDR_W-1:0]   in_dst;
  logic [ADDR_W-1:0]   in_src1;
  logic [ADDR_W-1:0]   in_src2;
  logic [DATA_W-1:0]   in_imm;

  logic [DATA_W-1:0]   alu_result;
  logic                alu_c;
  logic                alu_z;

  assign in_op   = instr[OP_MSB:OP_LSB];
  assign in_dst  = instr[DST_MSB:DST_LSB];
  assign in_src1 = instr[SRC1_MSB:SRC1_LSB];
  assign in_src2 = instr[SRC2_MSB:SRC2_LSB];
  assign in_imm  = instr[IMM_MSB:IMM_LSB];

  alu_core #(
    .DATA_W (DATA_W)
  ) u_alu (
    .op     (op_q),
    .a      (rd_data1),
    .b      (rd_data2),
    .result (alu_result),
    .c      (alu_c),
    .z      (alu_z)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      op_q       <= OP_NOP;
      dst_q      <= '0;
      src1_q     <= '0;
      src2_q     <= '0;
      result_q   <= '0;
      flag_z     <= 1'b0;
      flag_c     <= 1'b0;
      illegal_op <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (instr_valid) begin
            op_q   <= in_op;
            dst_q  <= in_dst;
            src1_q <= in_src1;
            src2_q <= in_src2;
            if (is_illegal(in_op)) begin
              illegal_op <= 1'b1;
            end
            if (in_op == OP_LDI) begin
              result_q <= in_imm;
              state    <= ST_WRITE;
            end else if (is_reg_op(in_op)) begin
              state <= ST_READ;
            end
          end
        end
        ST_READ: begin
          state <= ST_EXEC;
        end
        ST_EXEC: begin
          // Operands returned by the register file are valid only in this cycle.
          result_q <= alu_result;
          if (sets_flags(op_q)) begin
            flag_z <= alu_z;
            flag_c <= alu_c;
          end
          state <= ST_WRITE;
        end
        ST_WRITE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Port-side controls decode only registered state, so they hold steady
  // across the negedge where the register file commits.
  always_comb begin
    instr_ready = (state == ST_IDLE);
    busy        = (state != ST_IDLE);
    rd_en1      = (state == ST_READ) && is_reg_op(op_q);
    rd_en2      = (state == ST_READ) && uses_src2(op_q);
    rd_addr1    = (state == ST_READ) ? src1_q : '0;
    rd_addr2    = (state == ST_READ) ? src2_q : '0;
    wr_en       = (state == ST_WRITE);
    done        = (state == ST_WRITE);
    wr_addr     = (state == ST_WRITE) ? dst_q : '0;
    wr_data     = (state == ST_WRITE) ? result_q : '0;
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit with an attached register file: directed vectors,
// multi-cycle corner sequences and random instructions against an arithmetic model.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] instr = '0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [2:0]  rd_addr1, rd_addr2, wr_addr;
  logic        rd_en1, rd_en2, wr_en;
  logic [7:0]  rd_data1 = '0;
  logic [7:0]  rd_data2 = '0;
  logic [7:0]  wr_data;
  logic        busy, done, flag_z, flag_c, illegal_op;

  int checks = 0;
  int failures = 0;

  logic [7:0] rf [8] = '{default: 8'd0};

  int m_regs [8];
  bit m_z, m_c, m_illegal;

  alu_exec_unit #(
    .DATA_W (8),
    .ADDR_W (3)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .rd_addr1    (rd_addr1),
    .rd_addr2    (rd_addr2),
    .rd_en1      (rd_en1),
    .rd_en2      (rd_en2),
    .rd_data1    (rd_data1),
    .rd_data2    (rd_data2),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_en       (wr_en),
    .busy        (busy),
    .done        (done),
    .flag_z      (flag_z),
    .flag_c      (flag_c),
    .illegal_op  (illegal_op)
  );

  always #5 clk = ~clk;

  // Register file: registered reads, writes commit on the negedge.
  always @(posedge clk) begin
    if (rd_en1) rd_data1 <= rf[rd_addr1];
    if (rd_en2) rd_data2 <= rf[rd_addr2];
  end
  always @(negedge clk) begin
    if (wr_en) rf[wr_addr] <= wr_data;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [25:0] out_vec();
    return {instr_ready, busy, wr_en, done, rd_en1, rd_en2, flag_z, flag_c,
            illegal_op, wr_addr, wr_data, rd_addr1, rd_addr2};
  endfunction

  function automatic logic [15:0] mk(input int op, input int d, input int s1, input int s2);
    return {op[3:0], d[2:0], s1[2:0], s2[2:0], 3'b000};
  endfunction

  function automatic logic [15:0] mk_ldi(input int d, input int imm);
    return {4'h8, d[2:0], 1'b0, imm[7:0]};
  endfunction

  // Reference model: architectural effect of one accepted instruction.
  function automatic void model_step(input logic [15:0] ins);
    int op, d, a, b, imm, res;
    op  = int'(ins[15:12]);
    d   = int'(ins[11:9]);
    a   = m_regs[int'(ins[8:6])];
    b   = m_regs[int'(ins[5:3])];
    imm = int'(ins[7:0]);
    res = -1;
    case (op)
      1: begin res = (a + b) % 256;       m_c = (a + b) > 255; end
      2: begin res = (a - b + 256) % 256; m_c = a < b;         end
      3: begin res = a & b;               m_c = 1'b0;          end
      4: begin res = a | b;               m_c = 1'b0;          end
      5: begin res = a ^ b;               m_c = 1'b0;          end
      6: begin res = (a * 2) % 256;       m_c = a >= 128;      end
      7: begin res = a / 2;               m_c = (a % 2) == 1;  end
      8: m_regs[d] = imm;
      9: m_regs[d] = a;
      default: if (op >= 10) m_illegal = 1'b1;
    endcase
    if (res >= 0) begin
      m_regs[d] = res;
      m_z = (res == 0);
    end
  endfunction

  function automatic int model_lat(input int op);
    if ((op >= 1 && op <= 7) || op == 9) return 3;
    if (op == 8) return 1;
    return 0;
  endfunction

  function automatic bit model_e1(input int op);
    return (op >= 1 && op <= 7) || op == 9;
  endfunction

  function automatic bit model_e2(input int op);
    return op >= 1 && op <= 5;
  endfunction

  // Present one instruction, wait for acceptance, then watch the port
  // activity cycle by cycle until the expected done cycle (or one cycle for no-write ops).
  task automatic issue(input logic [15:0] ins, output int lat, output bit en_ok);
    int op, exp_lat, last, w;
    bit e1, e2;
    op      = int'(ins[15:12]);
    exp_lat = model_lat(op);
    e1      = model_e1(op);
    e2      = model_e2(op);
    lat     = 0;
    en_ok   = 1'b1;
    instr       = ins;
    instr_valid = 1'b1;
    w = 0;
    while (instr_ready !== 1'b1 && w < 10) begin
      @(negedge clk); #1;
      w++;
    end
    if (instr_ready !== 1'b1) chk("ready_timeout", 32'(instr_ready), 32'd1);
    @(posedge clk); #1;
    instr_valid = 1'b0;
    last = (exp_lat == 0) ? 1 : exp_lat;
    for (int n = 1; n <= last; n++) begin
      @(negedge clk); #1;
      if (rd_en1 !== (n == 1 && e1)) en_ok = 1'b0;
      if (rd_en2 !== (n == 1 && e2)) en_ok = 1'b0;
      if (wr_en !== (n == exp_lat)) en_ok = 1'b0;
      if (done !== (n == exp_lat)) en_ok = 1'b0;
      if (done === 1'b1 && lat == 0) lat = n;
    end
  endtask

  typedef struct {
    logic [15:0] instr;
    logic [7:0]  val;
    logic        z;
    logic        c;
    int          lat;
  } vec_t;

  vec_t tbl [15];

  initial begin
    int lat, acc, wt;
    bit en_ok, bad;
    logic [15:0] ins;
    logic [15:0] seq [4];
    logic [2:0]  dst;

    for (int r = 0; r < 8; r++) m_regs[r] = 0;
    m_z = 1'b0; m_c = 1'b0; m_illegal = 1'b0;

    tbl[0]  = '{mk_ldi(1, 200),   8'd200, 1'b0, 1'b0, 1};
    tbl[1]  = '{mk_ldi(2, 100),   8'd100, 1'b0, 1'b0, 1};
    tbl[2]  = '{mk(1, 3, 1, 2),   8'd44,  1'b0, 1'b1, 3};
    tbl[3]  = '{mk(2, 4, 2, 2),   8'd0,   1'b1, 1'b0, 3};
    tbl[4]  = '{mk(2, 5, 2, 1),   8'd156, 1'b0, 1'b1, 3};
    tbl[5]  = '{mk_ldi(6, 1),     8'd1,   1'b0, 1'b1, 1};
    tbl[6]  = '{mk(6, 6, 6, 0),   8'd2,   1'b0, 1'b0, 3};
    tbl[7]  = '{mk(6, 6, 6, 0),   8'd4,   1'b0, 1'b0, 3};
    tbl[8]  = '{mk(7, 6, 6, 0),   8'd2,   1'b0, 1'b0, 3};
    tbl[9]  = '{mk(9, 7, 3, 0),   8'd44,  1'b0, 1'b0, 3};
    tbl[10] = '{mk(5, 0, 3, 3),   8'd0,   1'b1, 1'b0, 3};
    tbl[11] = '{mk(3, 1, 1, 2),   8'd64,  1'b0, 1'b0, 3};
    tbl[12] = '{mk(4, 2, 3, 5),   8'd188, 1'b0, 1'b0, 3};
    tbl[13] = '{mk(6, 5, 5, 0),   8'd56,  1'b0, 1'b1, 3};
    tbl[14] = '{mk(1, 4, 4, 4),   8'd0,   1'b1, 1'b0, 3};

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_outputs", 32'(out_vec()), 32'(26'h2000000));
    rst_n = 1'b1;
    @(negedge clk); #1;

    // Directed vectors
    for (int i = 0; i < 15; i++) begin
      issue(tbl[i].instr, lat, en_ok);
      model_step(tbl[i].instr);
      dst = tbl[i].instr[11:9];
      chk($sformatf("vec%0d_val", i), 32'(rf[dst]), 32'(tbl[i].val));
      chk($sformatf("vec%0d_z", i), 32'(flag_z), 32'(tbl[i].z));
      chk($sformatf("vec%0d_c", i), 32'(flag_c), 32'(tbl[i].c));
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(tbl[i].lat));
      chk($sformatf("vec%0d_ports", i), 32'(en_ok), 32'd1);
    end

    // NOP stream then illegal op: one accept per cycle, no writes
    @(negedge clk); #1;
    seq[0] = mk(0, 1, 2, 3); seq[1] = mk(0, 4, 5, 6);
    seq[2] = mk(0, 7, 0, 1); seq[3] = mk(12, 2, 2, 2);
    acc = 0; bad = 1'b0;
    for (int k = 0; k < 4; k++) begin
      instr = seq[k];
      instr_valid = 1'b1;
      if (instr_ready === 1'b1) acc++;
      if (k == 3) chk("illegal_before", 32'(illegal_op), 32'd0);
      @(posedge clk); #1;
      model_step(seq[k]);
      if (wr_en !== 1'b0 || done !== 1'b0 || busy !== 1'b0) bad = 1'b1;
    end
    instr_valid = 1'b0;
    @(negedge clk); #1;
    if (wr_en !== 1'b0 || done !== 1'b0) bad = 1'b1;
    chk("stream_accepts", 32'(acc), 32'd4);
    chk("stream_no_write", 32'(bad), 32'd0);
    chk("illegal_set", 32'(illegal_op), 32'(m_illegal));
    ins = mk_ldi(0, 7);
    issue(ins, lat, en_ok);
    model_step(ins);
    chk("illegal_sticky", 32'(illegal_op), 32'd1);
    chk("after_illegal_r0", 32'(rf[0]), 32'(m_regs[0]));

    // Random instructions against the model
    for (int i = 0; i < 60; i++) begin
      ins = 16'($urandom);
      ins[15:12] = 4'($urandom_range(0, 9));
      issue(ins, lat, en_ok);
      model_step(ins);
      chk($sformatf("rand%0d_lat", i), 32'(lat), 32'(model_lat(int'(ins[15:12]))));
      chk($sformatf("rand%0d_ports", i), 32'(en_ok), 32'd1);
      for (int r = 0; r < 8; r++)
        chk($sformatf("rand%0d_r%0d", i, r), 32'(rf[r]), 32'(m_regs[r][7:0]));
      chk($sformatf("rand%0d_z", i), 32'(flag_z), 32'(m_z));
      chk($sformatf("rand%0d_c", i), 32'(flag_c), 32'(m_c));
    end

    // Asynchronous reset in the middle of a MOV's WRITE cycle
    ins = mk_ldi(7, 90);  issue(ins, lat, en_ok); model_step(ins);
    ins = mk_ldi(1, 165); issue(ins, lat, en_ok); model_step(ins);
    wt = 0;
    while (instr_ready !== 1'b1 && wt < 10) begin
      @(negedge clk); #1;
      wt++;
    end
    chk("rst_seq_idle", 32'(instr_ready), 32'd1);
    instr = mk(9, 7, 1, 0);
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    chk("rst_seq_in_write", 32'(done), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_write_outputs", 32'(out_vec()), 32'(26'h2000000));
    @(negedge clk); #1;
    chk("rst_r7_unchanged", 32'(rf[7]), 32'(m_regs[7][7:0]));
    m_z = 1'b0; m_c = 1'b0; m_illegal = 1'b0;
    rst_n = 1'b1;
    @(negedge clk); #1;
    ins = mk(2, 3, 1, 7);
    issue(ins, lat, en_ok);
    model_step(ins);
    chk("post_rst_val", 32'(rf[3]), 32'(m_regs[3][7:0]));
    chk("post_rst_c", 32'(flag_c), 32'(m_c));
    chk("post_rst_illegal", 32'(illegal_op), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
